datamemory_ls: RTL and testbench

- Parametrised successor to the pipeline's data memory. Adds a valid/ready request handshake and a registered response.
- Correct byte-lane placement for sub-word stores; loads extract from the addressed lane.
- Sign/zero extension for all RISC-V load sizes; 64-bit data option (LD/SD/LWU).
- Explicit misalignment and illegal-op reporting.
- Sits in the MEM stage; the pipeline stalls on req_ready low or rsp_valid not yet seen.

---
 rtl/datamemory_ls_if.sv | 28 ++
 rtl/datamemory_ls.sv | 170 +++++++++++++++++
 tb/tb_datamemory_ls.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/datamemory_ls_if.sv
// datamemory_ls_if: MEM-stage request/response bundle between the pipeline
// (master) and the data memory (slave).
interface datamemory_ls_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rd;
    logic                  misaligned;
    logic                  bad_op;

    modport master (
        output req_valid, MemRead, MemWrite, a, wd, Funct3,
        input  req_ready, rsp_valid, rd, misaligned, bad_op
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, a, wd, Funct3,
        output req_ready, rsp_valid, rd, misaligned, bad_op
    );
endinterface

// File: rtl/datamemory_ls.sv
// datamemory_ls: byte-addressable little-endian data memory with a valid/ready
// request, a registered one-cycle response, all RISC-V load/store sizes and
// misalignment / illegal-op flags.
// Optional feature macro DATAMEMORY_LS_MISALIGN_SPLIT_EN: misaligned accesses
// complete; word-crossing ones take an extra ACCESS2 cycle on the next word.
module datamemory_ls #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    datamemory_ls_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS   = $clog2(NB);
    localparam int unsigned IW    = DM_ADDRESS - OFS;
    localparam int unsigned WORDS = 1 << IW;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACCESS2, S_RESP} state_t;

    state_t                st;
    logic                  op_wr;
    logic [DM_ADDRESS-1:0] a_q;
    logic [DATA_W-1:0]     wd_q;
    logic [2:0]            f3_q;
    logic [DATA_W-1:0]     mem [WORDS];

    logic [IW-1:0]         idx_q;
    logic [OFS-1:0]        lane_q;
    int unsigned           lane_i;
    logic [3:0]            sz_bytes;
    int unsigned           szc;
    logic                  bad_c;
    logic                  ok_c;
    logic                  mis_flag_c;
    logic                  accept_c;
    logic [IW-1:0]         widx;
    logic [NB-1:0]         be;
    logic [DATA_W-1:0]     wbytes;
    logic [DATA_W-1:0]     rword;
    logic [2*DATA_W-1:0]   pair;
    logic [DATA_W-1:0]     raw;
    logic [DATA_W-1:0]     ld_c;
    logic                  sign;

    // Decode of the captured request
    assign idx_q    = a_q[DM_ADDRESS-1:OFS];
    assign lane_q   = a_q[OFS-1:0];
    assign lane_i   = 32'(lane_q);
    assign sz_bytes = 4'd1 << f3_q[1:0];
    assign szc      = (32'(sz_bytes) > NB) ? NB : 32'(sz_bytes);
    assign bad_c    = ((f3_q[1:0] == 2'b11) && (DATA_W != 64)) ||
                      (f3_q[2] && (op_wr || (32'(sz_bytes) >= NB)));
    assign accept_c = bus.req_valid && bus.req_ready && (bus.MemRead || bus.MemWrite);

`ifdef DATAMEMORY_LS_MISALIGN_SPLIT_EN
    logic              cross_c;
    logic [DATA_W-1:0] lo_q;
    assign cross_c    = (lane_i + 32'(sz_bytes)) > NB;
    assign ok_c       = !bad_c;
    assign mis_flag_c = 1'b0;
    assign pair       = (st == S_ACCESS2) ? {rword, lo_q} : {{DATA_W{1'b0}}, rword};
`else
    logic mis_c;
    assign mis_c      = (32'(a_q) & (32'(sz_bytes) - 32'd1)) != 32'd0;
    assign ok_c       = !bad_c && !mis_c;
    assign mis_flag_c = mis_c;
    assign pair       = {{DATA_W{1'b0}}, rword};
`endif

    // Word addressed this cycle and its raw contents
    assign widx  = (st == S_ACCESS2) ? idx_q + IW'(1) : idx_q;
    assign rword = mem[widx];
    assign raw   = DATA_W'(pair >> (lane_i << 3));

    // Byte-lane enables: access byte j lands at absolute lane position lane+j
    always_comb begin
        be     = '0;
        wbytes = '0;
        if (op_wr && ok_c && (st == S_ACCESS || st == S_ACCESS2)) begin
            for (int unsigned k = 0; k < NB; k++) begin
                for (int unsigned j = 0; j < NB; j++) begin
                    if (j < szc && (k + ((st == S_ACCESS2) ? NB : 0)) == (lane_i + j)) begin
                        be[k]            = 1'b1;
                        wbytes[8*k +: 8] = wd_q[8*j +: 8];
                    end
                end
            end
        end
    end

    // Sign/zero extension of the right-aligned load bytes
    always_comb begin
        ld_c = '0;
        sign = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (b + 1 == szc) sign = raw[8*b + 7];
        end
        for (int unsigned b = 0; b < NB; b++) begin
            if (b < szc)       ld_c[8*b +: 8] = raw[8*b +: 8];
            else if (f3_q[2])  ld_c[8*b +: 8] = 8'h00;
            else               ld_c[8*b +: 8] = {8{sign}};
        end
    end

    // Storage array; reset suppresses any write in flight
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= wbytes[8*k +: 8];
            end
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st             <= S_IDLE;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rd         <= '0;
            bus.misaligned <= 1'b0;
            bus.bad_op     <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (accept_c) begin
                        op_wr         <= bus.MemWrite;
                        a_q           <= bus.a;
                        wd_q          <= bus.wd;
                        f3_q          <= bus.Funct3;
                        st            <= S_ACCESS;
                        bus.req_ready <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    st             <= S_RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rd         <= (op_wr || !ok_c) ? '0 : ld_c;
                    bus.misaligned <= mis_flag_c;
                    bus.bad_op     <= bad_c;
`ifdef DATAMEMORY_LS_MISALIGN_SPLIT_EN
                    if (cross_c && !bad_c) begin
                        st            <= S_ACCESS2;
                        bus.rsp_valid <= 1'b0;
                        bus.rd        <= '0;
                        lo_q          <= rword;
                    end
`endif
                end
                S_ACCESS2: begin
                    st             <= S_RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rd         <= op_wr ? '0 : ld_c;
                    bus.misaligned <= 1'b0;
                    bus.bad_op     <= 1'b0;
                end
                S_RESP: begin
                    st             <= S_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.rsp_valid  <= 1'b0;
                    bus.rd         <= '0;
                    bus.misaligned <= 1'b0;
                    bus.bad_op     <= 1'b0;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_datamemory_ls.sv
// tb_datamemory_ls: randomized and directed stimulus against a byte-level
// reference model of the data memory (DATA_W=32, DM_ADDRESS=9).
module tb_datamemory_ls;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    datamemory_ls_if #(.DM_ADDRESS(9), .DATA_W(32)) bus();
    datamemory_ls #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte array, request timeline by edge count
    logic [7:0]  mm [512];
    int unsigned cyc = 0;
    int unsigned m_t = 0;
    bit          m_busy = 0;
    logic        m_wr = 1'b0;
    logic [8:0]  m_a = '0;
    logic [31:0] m_wd = '0;
    logic [2:0]  m_f3 = '0;
    bit          e_ready = 1;
    bit          e_rv = 0;
    bit          fresh = 1;
    logic [31:0] e_rd = '0;
    logic        e_mis = 1'b0;
    logic        e_bad = 1'b0;

    always @(posedge clk) begin
        int unsigned sz, ln, k;
        bit bad, mis, ok, split;
        logic [31:0] v;
        cyc++;
        e_rv = 0;
        if (!reset_n) begin
            m_busy = 0; e_ready = 1; fresh = 1;
            e_rd = '0; e_mis = 1'b0; e_bad = 1'b0;
        end else if (!m_busy) begin
            if (bus.req_valid && (bus.MemRead || bus.MemWrite)) begin
                m_wr = bus.MemWrite; m_a = bus.a; m_wd = bus.wd; m_f3 = bus.Funct3;
                m_t = cyc; m_busy = 1; e_ready = 0;
            end
        end else begin
            sz  = 1 << m_f3[1:0];
            ln  = m_a % 4;
            bad = (m_f3[1:0] == 2'b11) || (m_f3[2] && (m_wr || sz >= 4));
            mis = (m_a % sz) != 0;
`ifdef DATAMEMORY_LS_MISALIGN_SPLIT_EN
            ok = !bad; split = !bad && (ln + sz > 4);
`else
            ok = !bad && !mis; split = 0;
`endif
            k = cyc - m_t;
            if (m_wr && ok) begin
                for (int j = 0; j < sz; j++)
                    if ((k == 1) == (ln + j < 4)) mm[(m_a + j) % 512] = m_wd[8*j +: 8];
            end
            if (k == (split ? 2 : 1)) begin
                e_rv = 1; v = '0;
                if (!m_wr && ok) begin
                    for (int j = 0; j < sz; j++) v[8*j +: 8] = mm[(m_a + j) % 512];
                    if (!m_f3[2] && sz < 4 && v[8*sz-1])
                        for (int j = sz; j < 4; j++) v[8*j +: 8] = 8'hFF;
                end
                e_rd = v; e_bad = bad; fresh = 0;
`ifdef DATAMEMORY_LS_MISALIGN_SPLIT_EN
                e_mis = 1'b0;
`else
                e_mis = mis;
`endif
            end
            if (k == (split ? 3 : 2)) begin
                m_busy = 0; e_ready = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", 32'(bus.req_ready), 32'(e_ready));
            cmp("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            if (e_rv || fresh) begin
                cmp("rd", bus.rd, e_rd);
                cmp("misaligned", 32'(bus.misaligned), 32'(e_mis));
                cmp("bad_op", 32'(bus.bad_op), 32'(e_bad));
            end
        end
    end

    task automatic issue(input logic w, input logic r, input logic [8:0] ad,
                         input logic [31:0] d, input logic [2:0] f);
        int n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) cmp("issue_timeout", 32'(n), 32'd0);
        bus.req_valid = 1'b1; bus.MemWrite = w; bus.MemRead = r;
        bus.a = ad; bus.wd = d; bus.Funct3 = f;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] r, output logic m, output logic b, output int lat);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        if (lat >= 10) cmp("rsp_timeout", 32'(lat), 32'd0);
        r = bus.rd; m = bus.misaligned; b = bus.bad_op;
    endtask

    task automatic xfer(input string nm, input logic w, input logic [8:0] ad, input logic [31:0] d,
                        input logic [2:0] f, input logic [31:0] x_rd, input logic x_mis,
                        input logic x_bad, input int x_lat);
        logic [31:0] r; logic m, b; int lat;
        issue(w, !w, ad, d, f);
        get_rsp(r, m, b, lat);
        cmp({nm, "_rd"}, r, x_rd);
        cmp({nm, "_mis"}, 32'(m), 32'(x_mis));
        cmp({nm, "_bad"}, 32'(b), 32'(x_bad));
        cmp({nm, "_lat"}, 32'(lat), 32'(x_lat));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        logic [8:0]  ra;
        logic [2:0]  rf;
        int acc, seen, n, sel;
        bus.req_valid = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        bus.a = '0; bus.wd = '0; bus.Funct3 = '0;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        cmp("rst_ready", 32'(bus.req_ready), 32'd1);
        cmp("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        cmp("rst_rd", bus.rd, 32'd0);
        reset_n = 1'b1;

        // Give every word a known value
        for (int i = 0; i < 128; i++) issue(1'b1, 1'b0, 9'(i * 4), $urandom, 3'b010);
        repeat (3) @(negedge clk);

        xfer("sw10", 1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0, 1);
        xfer("lw10", 0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0, 1);
        xfer("sb13", 1, 9'h013, 32'h123456A5, 3'b000, 32'h0, 0, 0, 1);
        xfer("lw10b", 0, 9'h010, 32'h0, 3'b010, 32'hA5ADBEEF, 0, 0, 1);
        xfer("lb13", 0, 9'h013, 32'h0, 3'b000, 32'hFFFFFFA5, 0, 0, 1);
        xfer("lbu13", 0, 9'h013, 32'h0, 3'b100, 32'h000000A5, 0, 0, 1);
        xfer("lh12", 0, 9'h012, 32'h0, 3'b001, 32'hFFFFA5AD, 0, 0, 1);
        xfer("lhu12", 0, 9'h012, 32'h0, 3'b101, 32'h0000A5AD, 0, 0, 1);
        xfer("sh10", 1, 9'h010, 32'h7777, 3'b001, 32'h0, 0, 0, 1);
        xfer("lw10c", 0, 9'h010, 32'h0, 3'b010, 32'hA5AD7777, 0, 0, 1);
`ifdef DATAMEMORY_LS_MISALIGN_SPLIT_EN
        xfer("sw1fe", 1, 9'h1FE, 32'h11223344, 3'b010, 32'h0, 0, 0, 2);
        xfer("lw1fe", 0, 9'h1FE, 32'h0, 3'b010, 32'h11223344, 0, 0, 2);
        xfer("lbu1ff", 0, 9'h1FF, 32'h0, 3'b100, 32'h00000033, 0, 0, 1);
        xfer("lbu000", 0, 9'h000, 32'h0, 3'b100, 32'h00000022, 0, 0, 1);
        xfer("lbu001", 0, 9'h001, 32'h0, 3'b100, 32'h00000011, 0, 0, 1);
`else
        xfer("lw11", 0, 9'h011, 32'h0, 3'b010, 32'h0, 1, 0, 1);
        xfer("sw11", 1, 9'h011, 32'h0, 3'b010, 32'h0, 1, 0, 1);
        xfer("lw10d", 0, 9'h010, 32'h0, 3'b010, 32'hA5AD7777, 0, 0, 1);
`endif
        xfer("ld_bad", 0, 9'h010, 32'h0, 3'b111, 32'h0, 0, 1, 1);
        xfer("st_bad", 1, 9'h010, 32'h0, 3'b111, 32'h0, 0, 1, 1);
        xfer("lw10e", 0, 9'h010, 32'h0, 3'b010, 32'hA5AD7777, 0, 0, 1);

        // req_valid held high through busy periods
        @(negedge clk);
        bus.req_valid = 1'b1; bus.MemRead = 1'b1; bus.a = 9'h010; bus.Funct3 = 3'b010;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.req_ready === 1'b1) acc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0; bus.MemRead = 1'b0;
        cmp("held_accepts", 32'(acc), 32'd3);
        repeat (3) @(negedge clk);

        // Valid with no operation is ignored
        bus.req_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        bus.req_valid = 1'b0;
        cmp("noop_rsp", 32'(seen), 32'd0);
        cmp("noop_ready", 32'(bus.req_ready), 32'd1);

        // Reset at the ACCESS edge drops the store
        prev = {mm[9'h023], mm[9'h022], mm[9'h021], mm[9'h020]};
        issue(1'b1, 1'b0, 9'h020, 32'hCAFEF00D, 3'b010);
        reset_n = 1'b0;
        @(negedge clk);
        cmp("racc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        cmp("racc_rd", bus.rd, 32'd0);
        cmp("racc_mis", 32'(bus.misaligned), 32'd0);
        cmp("racc_bad", 32'(bus.bad_op), 32'd0);
        cmp("racc_ready", 32'(bus.req_ready), 32'd1);
        reset_n = 1'b1;
        xfer("lw20", 0, 9'h020, 32'h0, 3'b010, prev, 0, 0, 1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            ra  = 9'($urandom);
            rf  = 3'($urandom);
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            issue(sel < 4, sel >= 4 && sel < 9, ra, $urandom, rf);
        end
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
